bgm_sequencer: RTL

Background-music sequencer feeding the tone generator. It watches the game `state` code and steps through a per-state melody at a fixed beat rate. It emits registered left/right note-divider words for `note_gen`, which turns them into audio samples for `speaker_control`. Changing the game state restarts playback from the first note of the newly selected track.

---
 rtl/bgm_pkg.sv | 52 +++++
 rtl/bgm_rom.sv | 115 +++++++++++
 rtl/bgm_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/bgm_pkg.sv
// Shared definitions for the background-music sequencer: game-state codes,
// note divider words, track identifiers and track lengths.
package bgm_pkg;

  localparam int DIV_W = 22;

  localparam logic [3:0] ST_TITLE    = 4'd0;
  localparam logic [3:0] ST_STAGE_LO = 4'd1;
  localparam logic [3:0] ST_STAGE_HI = 4'd4;
  localparam logic [3:0] ST_WIN      = 4'd5;
  localparam logic [3:0] ST_LOSE     = 4'd6;

  // Divider words are CLK_HZ / note frequency for a 100 MHz system clock.
  localparam logic [DIV_W-1:0] NOTE_C4 = 22'd382219;
  localparam logic [DIV_W-1:0] NOTE_E4 = 22'd303370;
  localparam logic [DIV_W-1:0] NOTE_G4 = 22'd255102;
  localparam logic [DIV_W-1:0] NOTE_C5 = 22'd191113;
  localparam logic [DIV_W-1:0] REST    = 22'd0;

  typedef enum logic [2:0] {
    TRK_T,
    TRK_S,
    TRK_W,
    TRK_L,
    TRK_NONE
  } track_t;

  localparam int LOOP_LEN   = 64;
  localparam int JINGLE_LEN = 16;

  // Maps a game-state code onto the track that should be playing.
  function automatic track_t track_of(input logic [3:0] st);
    track_t trk;
    if (st == ST_TITLE)
      trk = TRK_T;
    else if (st >= ST_STAGE_LO && st <= ST_STAGE_HI)
      trk = TRK_S;
    else if (st == ST_WIN)
      trk = TRK_W;
    else if (st == ST_LOSE)
      trk = TRK_L;
    else
      trk = TRK_NONE;
    return trk;
  endfunction

  // Jingles play once and then fall silent; the main tracks loop forever.
  function automatic logic is_one_shot(input track_t trk);
    return (trk == TRK_W) || (trk == TRK_L);
  endfunction

endpackage

// File: rtl/bgm_rom.sv
// Melody ROM: maps (track, note index) to left melody and right harmony
// divider words. Purely combinational; the sequencer registers the result.
module bgm_rom
  import bgm_pkg::*;
(
  input  track_t           track,
  input  logic [5:0]       idx,
  output logic [DIV_W-1:0] div_left,
  output logic [DIV_W-1:0] div_right
);

  logic [DIV_W-1:0] root;

  // Looping tracks reuse a 16-step melody and hang a per-phrase harmony root
  // under it; the jingles are spelled out note by note.
  always_comb begin
    div_left  = REST;
    div_right = REST;
    root      = REST;
    case (track)
      TRK_T: begin
        case (idx[3:0])
          4'd0:  div_left = NOTE_C4;
          4'd1:  div_left = NOTE_E4;
          4'd2:  div_left = NOTE_G4;
          4'd3:  div_left = NOTE_C5;
          4'd4:  div_left = NOTE_G4;
          4'd5:  div_left = NOTE_E4;
          4'd6:  div_left = NOTE_C4;
          4'd7:  div_left = REST;
          4'd8:  div_left = NOTE_E4;
          4'd9:  div_left = NOTE_G4;
          4'd10: div_left = NOTE_C5;
          4'd11: div_left = NOTE_G4;
          4'd12: div_left = NOTE_E4;
          4'd13: div_left = NOTE_C4;
          4'd14: div_left = NOTE_C4;
          default: div_left = REST;
        endcase
        case (idx[5:4])
          2'd0:    root = NOTE_C4;
          2'd1:    root = NOTE_E4;
          2'd2:    root = NOTE_G4;
          default: root = NOTE_E4;
        endcase
        div_right = (idx[2:0] == 3'd3) ? REST : root;
      end
      TRK_S: begin
        case (idx[3:0])
          4'd0:  div_left = NOTE_G4;
          4'd1:  div_left = NOTE_C5;
          4'd2:  div_left = NOTE_G4;
          4'd3:  div_left = NOTE_E4;
          4'd4:  div_left = NOTE_G4;
          4'd5:  div_left = NOTE_C5;
          4'd6:  div_left = NOTE_G4;
          4'd7:  div_left = REST;
          4'd8:  div_left = NOTE_E4;
          4'd9:  div_left = NOTE_G4;
          4'd10: div_left = NOTE_E4;
          4'd11: div_left = NOTE_C4;
          4'd12: div_left = REST;
          4'd13: div_left = NOTE_C4;
          4'd14: div_left = NOTE_E4;
          default: div_left = NOTE_C4;
        endcase
        root      = idx[4] ? NOTE_G4 : NOTE_C4;
        div_right = (idx[2:0] == 3'd5) ? REST : root;
      end
      TRK_W: begin
        case (idx[3:0])
          4'd0:  {div_left, div_right} = {NOTE_C4, NOTE_C4};
          4'd1:  {div_left, div_right} = {NOTE_E4, NOTE_C4};
          4'd2:  {div_left, div_right} = {NOTE_G4, NOTE_E4};
          4'd3:  {div_left, div_right} = {NOTE_C5, NOTE_E4};
          4'd4:  {div_left, div_right} = {NOTE_C4, NOTE_G4};
          4'd5:  {div_left, div_right} = {NOTE_E4, NOTE_G4};
          4'd6:  {div_left, div_right} = {NOTE_G4, NOTE_C5};
          4'd7:  {div_left, div_right} = {NOTE_C5, NOTE_C5};
          4'd8:  {div_left, div_right} = {NOTE_C5, REST};
          4'd9:  {div_left, div_right} = {REST, REST};
          4'd10: {div_left, div_right} = {NOTE_C5, NOTE_G4};
          4'd11: {div_left, div_right} = {REST, REST};
          4'd12: {div_left, div_right} = {NOTE_C5, NOTE_G4};
          default: {div_left, div_right} = {REST, REST};
        endcase
      end
      TRK_L: begin
        case (idx[3:0])
          4'd0:  {div_left, div_right} = {NOTE_C5, NOTE_E4};
          4'd1:  {div_left, div_right} = {NOTE_G4, NOTE_C4};
          4'd2:  {div_left, div_right} = {NOTE_E4, REST};
          4'd3:  {div_left, div_right} = {NOTE_C4, REST};
          4'd4:  {div_left, div_right} = {REST, NOTE_E4};
          4'd5:  {div_left, div_right} = {NOTE_C5, NOTE_C4};
          4'd6:  {div_left, div_right} = {NOTE_G4, REST};
          4'd7:  {div_left, div_right} = {NOTE_E4, REST};
          4'd8:  {div_left, div_right} = {NOTE_C4, NOTE_C4};
          4'd9:  {div_left, div_right} = {REST, REST};
          4'd10: {div_left, div_right} = {NOTE_E4, NOTE_C4};
          4'd11: {div_left, div_right} = {NOTE_C4, REST};
          4'd12: {div_left, div_right} = {NOTE_C4, NOTE_C4};
          4'd13: {div_left, div_right} = {REST, REST};
          4'd14: {div_left, div_right} = {NOTE_C4, REST};
          default: {div_left, div_right} = {REST, REST};
        endcase
      end
      default: begin
        div_left  = REST;
        div_right = REST;
      end
    endcase
  end

endmodule

// File: rtl/bgm_sequencer.sv
// Background-music sequencer: follows the game state, steps through the
// selected track at a fixed beat rate and presents registered divider words
// for the tone generator, with a short articulation rest at each beat end.
module bgm_sequencer
  import bgm_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BEAT_HZ = 8,
  parameter int GAP_CYC = 1_250_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       state,
  output logic [DIV_W-1:0] note_div_left,
  output logic [DIV_W-1:0] note_div_right,
  output logic             beat_tick,
  output logic [5:0]       note_idx,
  output logic             done
);

  localparam int BEAT_DIV = CLK_HZ / BEAT_HZ - 1;
  localparam int PRE_W    = (BEAT_DIV > 0) ? $clog2(BEAT_DIV + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(BEAT_DIV);

  // A gap longer than the beat simply silences the whole beat.
  localparam bit GAP_EN      = (GAP_CYC > 0);
  localparam int GAP_START_I = (GAP_CYC >= BEAT_DIV + 1) ? 0 : BEAT_DIV + 1 - GAP_CYC;
  localparam logic [PRE_W-1:0] GAP_START = PRE_W'(GAP_START_I);

  localparam logic [5:0] LOOP_LAST   = 6'(LOOP_LEN - 1);
  localparam logic [5:0] JINGLE_LAST = 6'(JINGLE_LEN - 1);

  logic [PRE_W-1:0] pre, pre_d;
  logic [3:0]       state_q, state_q_d;
  logic [5:0]       idx_d;
  logic             done_d;
  logic             tick_d;
  logic             silence;
  track_t           track;
  logic [DIV_W-1:0] rom_left, rom_right;
  logic [DIV_W-1:0] left_d, right_d;

  assign track = track_of(state_q);

  bgm_rom u_rom (
    .track     (track),
    .idx       (note_idx),
    .div_left  (rom_left),
    .div_right (rom_right)
  );

  // Next-state for the beat prescaler and melody position; a state change
  // wins over a coincident beat and restarts the new track from note 0.
  always_comb begin
    pre_d     = pre;
    idx_d     = note_idx;
    done_d    = done;
    state_q_d = state_q;
    tick_d    = 1'b0;
    if (state != state_q) begin
      pre_d     = '0;
      idx_d     = '0;
      done_d    = 1'b0;
      state_q_d = state;
    end else if (pre == PRE_MAX) begin
      pre_d  = '0;
      tick_d = 1'b1;
      if (track == TRK_NONE) begin
        idx_d = '0;
      end else if (is_one_shot(track)) begin
        if (note_idx == JINGLE_LAST)
          done_d = 1'b1;
        else
          idx_d = note_idx + 6'd1;
      end else begin
        idx_d = (note_idx == LOOP_LAST) ? 6'd0 : note_idx + 6'd1;
      end
    end else begin
      pre_d = pre + PRE_W'(1);
    end
  end

  // Dividers are muted for silent states, finished jingles and the
  // articulation gap; otherwise they follow the ROM.
  always_comb begin
    silence = (track == TRK_NONE) || done || (GAP_EN && (pre >= GAP_START));
    left_d  = silence ? REST : rom_left;
    right_d = silence ? REST : rom_right;
  end

  // All sequencer state and the registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre            <= '0;
      note_idx       <= '0;
      state_q        <= ST_TITLE;
      done           <= 1'b0;
      beat_tick      <= 1'b0;
      note_div_left  <= REST;
      note_div_right <= REST;
    end else begin
      pre            <= pre_d;
      note_idx       <= idx_d;
      state_q        <= state_q_d;
      done           <= done_d;
      beat_tick      <= tick_d;
      note_div_left  <= left_d;
      note_div_right <= right_d;
    end
  end

endmodule
